// File: rtl/vram_arb_pkg.sv
// Shared types and default sizes for the VRAM time-division arbiter.
package vram_arb_pkg;

    localparam int unsigned SlotLenDefault = 8;
    localparam int unsigned AddrWDefault   = 16;
    localparam int unsigned DataWDefault   = 8;

    typedef enum logic [1:0] {
        StIdle,
        StVdpRd,
        StCpuRd,
        StCpuWr
    } arb_state_e;

    // Owner of the access in flight; steers ram_rdata one cycle later.
    typedef enum logic [1:0] {
        TagNone,
        TagVdp,
        TagCpu
    } ret_tag_e;

endpackage

// File: rtl/vram_slot_phase.sv
// Slot phase counter aligned to the VDP character period; vdp_sync realigns it to dot 0.
module vram_slot_phase
    import vram_arb_pkg::*;
#(
    parameter int unsigned SLOT_LEN = SlotLenDefault
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        vdp_sync,
    output logic [$clog2(SLOT_LEN)-1:0] phase,
    output logic                        vdp_grant_next
);

    localparam int unsigned PhaseW = $clog2(SLOT_LEN);
    localparam logic [PhaseW-1:0] LastPhase  = PhaseW'(SLOT_LEN - 1);
    localparam logic [PhaseW-1:0] GrantPhase = PhaseW'(SLOT_LEN - 2);

    logic [PhaseW-1:0] phase_q;
    logic [PhaseW-1:0] phase_d;

    always_comb begin
        if (vdp_sync || (phase_q == LastPhase)) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PhaseW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase          = phase_q;
    assign vdp_grant_next = (phase_q == GrantPhase);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: one reserved VDP read per slot, remaining cycles serve the CPU.
// Define VRAM_ARB_BLANK_FREE_EN to add vdp_visible and hand the VDP slot to the CPU in blanking.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned SLOT_LEN = SlotLenDefault,
    parameter int unsigned ADDR_W   = AddrWDefault,
    parameter int unsigned DATA_W   = DataWDefault
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vdp_sync,
    input  logic [ADDR_W-1:0] vdp_addr,
`ifdef VRAM_ARB_BLANK_FREE_EN
    input  logic              vdp_visible,
`endif
    output logic [DATA_W-1:0] vdp_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned PhaseW = $clog2(SLOT_LEN);

    logic [PhaseW-1:0] phase;
    logic              vdp_grant_next;
    logic              vdp_grant;
    logic              cpu_accept;

    arb_state_e        state_q, state_d;
    ret_tag_e          tag_q, tag_d;
    logic              busy_q, busy_d;
    logic              ack_q;
    logic [DATA_W-1:0] vdp_data_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [DATA_W-1:0] lat_wdata_q;

    vram_slot_phase #(
        .SLOT_LEN(SLOT_LEN)
    ) u_slot_phase (
        .clk           (clk),
        .reset         (reset),
        .vdp_sync      (vdp_sync),
        .phase         (phase),
        .vdp_grant_next(vdp_grant_next)
    );

`ifdef VRAM_ARB_BLANK_FREE_EN
    assign vdp_grant = vdp_grant_next && vdp_visible;
`else
    assign vdp_grant = vdp_grant_next;
`endif

    assign cpu_accept = cpu_req && !busy_q && !vdp_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StIdle;
        if (vdp_grant) begin
            state_d = StVdpRd;
        end else if (cpu_accept) begin
            state_d = cpu_we ? StCpuWr : StCpuRd;
        end
        // Busy spans accept through the ack cycle, so a held req is not re-accepted early.
        busy_d = busy_q;
        if (cpu_accept) begin
            busy_d = 1'b1;
        end else if (ack_q) begin
            busy_d = 1'b0;
        end
    end

    always_comb begin
        ram_addr  = lat_addr_q;
        ram_we    = 1'b0;
        ram_wdata = lat_wdata_q;
        tag_d     = TagNone;
        unique case (state_q)
            StIdle: begin
            end
            StVdpRd: begin
                ram_addr = vdp_addr;
                tag_d    = TagVdp;
            end
            StCpuRd: begin
                tag_d = TagCpu;
            end
            StCpuWr: begin
                ram_we = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            tag_q       <= TagNone;
            vdp_data_q  <= '0;
            cpu_rdata_q <= '0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
            ack_q  <= (state_q == StCpuWr) || (tag_q == TagCpu);
            if (cpu_accept) begin
                lat_addr_q  <= cpu_addr;
                lat_wdata_q <= cpu_wdata;
            end
            if (tag_q == TagVdp) begin
                vdp_data_q <= ram_rdata;
            end
            if (tag_q == TagCpu) begin
                cpu_rdata_q <= ram_rdata;
            end
        end
    end

    assign vdp_data  = vdp_data_q;
    assign cpu_ack   = ack_q;
    assign cpu_rdata = cpu_rdata_q;

    // Outside a sync realign, the VDP read must land on the last dot of the slot.
    assert property (@(posedge clk) disable iff (reset)
        ((state_q == StVdpRd) && !$past(vdp_sync)) |-> (phase == PhaseW'(SLOT_LEN - 1)));

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: vector table, ack scoreboard and corner-case sequences.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vdp_sync = 1'b0;
    logic [15:0] vdp_addr = 16'h1234;
    logic [7:0]  vdp_data;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [7:0]  cpu_wdata = 8'h0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h0;

    vram_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .vdp_sync (vdp_sync),
        .vdp_addr (vdp_addr),
`ifdef VRAM_ARB_BLANK_FREE_EN
        .vdp_visible(1'b1),
`endif
        .vdp_data (vdp_data),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_ack  (cpu_ack),
        .cpu_rdata(cpu_rdata),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM model
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Independent phase model
    logic [2:0] ph_m;
    always @(posedge clk) begin
        if (reset || vdp_sync) ph_m <= 3'd0;
        else ph_m <= ph_m + 3'd1;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        is_read;
        logic [15:0] addr;
        logic [7:0]  rdata;
    } sb_t;
    sb_t sb[$];
    logic [7:0] ref_mem [int];
    logic [15:0] last_addr = 16'h0;

    always @(negedge clk) begin
        if (!reset && cpu_ack) begin
            chk("ack_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                sb_t e;
                e = sb.pop_front();
                if (e.is_read) chk("read_data", 32'(cpu_rdata), 32'(e.rdata));
            end
        end
    end

    task automatic wait_phase(input logic [2:0] p);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ph_m != p && n < 20);
        if (ph_m != p) chk("wait_phase_timeout", 32'd1, 32'd0);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [2:0]  start_ph;
        int          lat;
    } vec_t;
    vec_t vecs[8];

    task automatic run_vec(input vec_t v);
        int lat;
        int idx;
        bit got;
        logic        we_h [32];
        logic [15:0] ad_h [32];
        wait_phase(v.start_ph);
        cpu_req = 1'b1;
        cpu_we = v.we;
        cpu_addr = v.addr;
        cpu_wdata = v.wdata;
        if (v.we) ref_mem[v.addr] = v.wdata;
        sb.push_back('{!v.we, v.addr, v.we ? 8'h00 : ref_mem[v.addr]});
        lat = 0;
        got = 0;
        while (!got && lat < 24) begin
            @(negedge clk);
            we_h[lat] = ram_we;
            ad_h[lat] = ram_addr;
            if (cpu_ack) got = 1;
            else begin
                lat++;
                @(posedge clk); #1;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        if (got) begin
            chk("latency", 32'(lat), 32'(v.lat));
            idx = v.we ? lat - 1 : lat - 2;
            if (idx >= 0) begin
                chk("access_we", 32'(we_h[idx]), 32'(v.we));
                chk("access_addr", 32'(ad_h[idx]), 32'(v.addr));
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        last_addr = v.addr;
        if (v.we) chk("ram_content", 32'(mem[v.addr]), 32'(v.wdata));
    endtask

    initial begin
        int acks;
        int lat;
        bit got;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int lat;
        bit got;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1234] = 8'hA5;

        vecs[0] = '{1'b1, 16'h0100, 8'h3C, 3'd0, 2};
        vecs[1] = '{1'b0, 16'h0100, 8'h00, 3'd6, 4};
        vecs[2] = '{1'b1, 16'h2000, 8'h5A, 3'd3, 2};
        vecs[3] = '{1'b0, 16'h2000, 8'h00, 3'd2, 3};
        vecs[4] = '{1'b1, 16'h2001, 8'h77, 3'd6, 3};
        vecs[5] = '{1'b0, 16'h2001, 8'h00, 3'd5, 3};
        vecs[6] = '{1'b1, 16'h0200, 8'hC3, 3'd5, 2};
        vecs[7] = '{1'b0, 16'h0100, 8'h00, 3'd4, 3};

        // Reset, then idle: VDP fetch at every phase 7, byte visible from phase 1 of slot 2
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ack", 32'(cpu_ack), 32'd0);
        chk("rst_vdp_data", 32'(vdp_data), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        @(posedge clk); #1;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            chk("idle_ram_addr", 32'(ram_addr), (k % 8 == 7) ? 32'h1234 : 32'h0);
            chk("idle_ram_we", 32'(ram_we), 32'd0);
            chk("idle_vdp_data", 32'(vdp_data), (k >= 9) ? 32'hA5 : 32'h0);
            chk("idle_ack", 32'(cpu_ack), 32'd0);
            @(posedge clk); #1;
        end

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Held request: ack cycle performs no access, renewed request is a fresh access
        wait_phase(3'd0);
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 16'h3000;
        cpu_wdata = 8'h11;
        sb.push_back('{1'b0, 16'h3000, 8'h00});
        acks = 0;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (cpu_ack) got = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("hold_ack1_seen", 32'(got), 32'd1);
        acks += int'(got);
        chk("hold_ack_cycle_no_we", 32'(ram_we), 32'd0);
        @(posedge clk); #1;
        cpu_addr = 16'h3001;
        cpu_wdata = 8'h22;
        sb.push_back('{1'b0, 16'h3001, 8'h00});
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            if (cpu_ack) got = 1;
            else begin
                lat++;
                @(posedge clk); #1;
            end
        end
        acks += int'(got);
        chk("hold_renew_latency", 32'(lat), 32'd2);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        last_addr = 16'h3001;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (cpu_ack) acks++;
            @(posedge clk); #1;
        end
        chk("hold_ack_count", 32'(acks), 32'd2);
        chk("hold_mem_a", 32'(mem[16'h3000]), 32'h11);
        chk("hold_mem_b", 32'(mem[16'h3001]), 32'h22);

        // Sync at phase 3: phase restarts, next VDP read 7 cycles into the new slot
        wait_phase(3'd3);
        vdp_sync = 1'b1;
        @(posedge clk); #1;
        vdp_sync = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("sync_ram_addr", 32'(ram_addr), (k == 7) ? 32'h1234 : 32'(last_addr));
            @(posedge clk); #1;
        end
        chk("sync_vdp_data", 32'(vdp_data), 32'hA5);

        // Reset during CPU_RD abandons the access
        wait_phase(3'd1);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 16'h2000;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rdrst_access_addr", 32'(ram_addr), 32'h2000);
        reset = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rdrst_ack", 32'(cpu_ack), 32'd0);
        chk("rdrst_vdp_data", 32'(vdp_data), 32'd0);
        chk("rdrst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rdrst_ram_we", 32'(ram_we), 32'd0);
        chk("rdrst_ram_addr", 32'(ram_addr), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        acks = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (cpu_ack) acks++;
            @(posedge clk); #1;
        end
        chk("rdrst_no_ack", 32'(acks), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
